uart_cmd_handler_mc: RTL and testbench

- Parametrised multi-channel successor of the trigger-delay UART command handler.
- Parses byte-framed commands from the UART receiver and drives per-channel delay, edge and counter-reset controls for NUM_CH trigger delay channels.
- Returns ACK, NAK or data bytes through the UART transmitter using a full tx_ready handshake.
- Adds channel addressing, broadcast, NAK on bad requests, and an inter-byte timeout.

---
 rtl/uart_cmd_handler_mc.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_cmd_handler_mc.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_handler_mc.sv
// rtl/uart_cmd_handler_mc.sv - multi-channel trigger-delay UART command handler
//
// Parses byte-framed requests (cmd, ch, little-endian payload) from a UART
// receiver, drives per-channel delay / edge / counter-reset controls for
// NUM_CH trigger delay channels and answers with ACK, NAK or data bytes
// through a UART transmitter using a tx_en / tx_ready handshake.
//
// Optional feature macro: CMD_CHECKSUM_EN
//   When defined, every request carries a trailing XOR checksum byte (checked
//   in GET_CSUM) and every response is followed by its own XOR checksum byte.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_data[7:0]        received byte, qualified by rx_data_valid
//   tx_data[7:0]        byte to transmit, qualified by one-cycle tx_en
//   tx_ready            transmitter idle; low while a byte is being sent
//   delay_cycles        per-channel delay, channel c at [c*DELAY_W +: DELAY_W]
//   delay_update        per-channel one-cycle delay update pulse
//   edge_type           per-channel edge select (0 none, 1 rise, 2 fall, 3 both)
//   edge_type_update    per-channel one-cycle edge update pulse
//   current_delay       live delay per channel (GET_DELAY / GET_STATUS source)
//   trigger_count       trigger count per channel (GET_STATUS source)
//   reset_counter       per-channel one-cycle counter reset pulse
module uart_cmd_handler_mc #(
    parameter int         NUM_CH         = 4,
    parameter int         DELAY_W        = 32,
    parameter int         COUNT_W        = 16,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = 8'h55,
    parameter logic [7:0] ACK_BYTE       = 8'hAA,
    parameter logic [7:0] NAK_BYTE       = 8'hEE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_data_valid,
    output logic [7:0]                  tx_data,
    output logic                        tx_en,
    input  logic                        tx_ready,
    output logic [NUM_CH*DELAY_W-1:0]   delay_cycles,
    output logic [NUM_CH-1:0]           delay_update,
    output logic [NUM_CH*2-1:0]         edge_type,
    output logic [NUM_CH-1:0]           edge_type_update,
    input  logic [NUM_CH*DELAY_W-1:0]   current_delay,
    input  logic [NUM_CH*COUNT_W-1:0]   trigger_count,
    output logic [NUM_CH-1:0]           reset_counter
);

    localparam int DB      = (DELAY_W + 7) / 8;
    localparam int CB      = (COUNT_W + 7) / 8;
    localparam int RB_DATA = (CB + DB > 3) ? CB + DB : 3;
`ifdef CMD_CHECKSUM_EN
    localparam int RB      = RB_DATA + 1;
`else
    localparam int RB      = RB_DATA;
`endif
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_SET_DELAY   = 8'h01;
    localparam logic [7:0] CMD_GET_DELAY   = 8'h02;
    localparam logic [7:0] CMD_SET_EDGE    = 8'h03;
    localparam logic [7:0] CMD_GET_EDGE    = 8'h04;
    localparam logic [7:0] CMD_GET_STATUS  = 8'h05;
    localparam logic [7:0] CMD_RESET_COUNT = 8'h06;
    localparam logic [7:0] CMD_GET_INFO    = 8'h07;
    localparam logic [7:0] CH_BROADCAST    = 8'hFF;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_GET_CH      = 3'd1;
    localparam logic [2:0] S_GET_PAYLOAD = 3'd2;
    localparam logic [2:0] S_EXEC        = 3'd4;
    localparam logic [2:0] S_TX_LOAD     = 3'd5;
    localparam logic [2:0] S_TX_WAIT     = 3'd6;
`ifdef CMD_CHECKSUM_EN
    localparam logic [2:0] S_GET_CSUM    = 3'd3;
    localparam logic [2:0] S_REQ_END     = S_GET_CSUM;
`else
    localparam logic [2:0] S_REQ_END     = S_EXEC;
`endif

    logic [2:0]         state;
    logic [7:0]         cmd;
    logic [7:0]         ch;
    logic [DB*8-1:0]    payload;
    logic [2:0]         pay_cnt;
    logic               nak_flag;
    logic [31:0]        timer;
    logic [7:0]         resp [RB];
    logic [3:0]         resp_len;
    logic [3:0]         resp_idx;
    logic               seen_low;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]         csum;
    logic               csum_bad;
    logic [7:0]         rsum;
`endif

    logic               rx_known;
    logic               receiving;
    logic               timed_out;
    logic [2:0]         pay_need;
    logic [DELAY_W-1:0] sel_delay;
    logic [COUNT_W-1:0] sel_count;
    logic [1:0]         sel_edge;
    logic [NUM_CH-1:0]  ch_mask;
    logic               ch_hit;
    logic               bcast_ok;
    logic               req_bad;
    logic [DB*8-1:0]    dly_pad;
    logic [CB*8-1:0]    cnt_pad;
    logic [7:0]         resp_n [RB];
    logic [3:0]         resp_len_n;
    logic [7:0]         tx_byte;

    assign rx_known  = (rx_data >= CMD_SET_DELAY) && (rx_data <= CMD_GET_INFO);
    assign pay_need  = (cmd == CMD_SET_DELAY) ? 3'(DB) : 3'd1;
`ifdef CMD_CHECKSUM_EN
    assign receiving = (state == S_GET_CH) || (state == S_GET_PAYLOAD) || (state == S_GET_CSUM);
`else
    assign receiving = (state == S_GET_CH) || (state == S_GET_PAYLOAD);
`endif
    assign timed_out = receiving && !rx_data_valid && (timer == TO_LAST);

    // Channel decode, validation and response image; registered in EXEC so
    // get responses are a snapshot of the inputs at that cycle.
    always_comb begin
        sel_delay = '0;
        sel_count = '0;
        sel_edge  = '0;
        ch_mask   = '0;
        ch_hit    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == 8'(c)) begin
                sel_delay  = current_delay[c*DELAY_W +: DELAY_W];
                sel_count  = trigger_count[c*COUNT_W +: COUNT_W];
                sel_edge   = edge_type[c*2 +: 2];
                ch_mask[c] = 1'b1;
                ch_hit     = 1'b1;
            end
        end
        bcast_ok = (ch == CH_BROADCAST) &&
                   (cmd == CMD_SET_DELAY || cmd == CMD_SET_EDGE || cmd == CMD_RESET_COUNT);
        if (bcast_ok) begin
            ch_mask = '1;
        end
        req_bad = nak_flag ||
                  (cmd != CMD_GET_INFO && !ch_hit && !bcast_ok) ||
                  (cmd == CMD_SET_EDGE && payload[7:0] > 8'd3);
`ifdef CMD_CHECKSUM_EN
        req_bad = req_bad || csum_bad;
`endif
        dly_pad = (DB*8)'(sel_delay);
        cnt_pad = (CB*8)'(sel_count);

        for (int i = 0; i < RB; i++) begin
            resp_n[i] = '0;
        end
        resp_len_n = 4'd1;
        resp_n[0]  = ACK_BYTE;
        if (req_bad) begin
            resp_n[0] = NAK_BYTE;
        end else begin
            case (cmd)
                CMD_GET_DELAY: begin
                    for (int i = 0; i < DB; i++) resp_n[i] = dly_pad[i*8 +: 8];
                    resp_len_n = 4'(DB);
                end
                CMD_GET_EDGE: begin
                    resp_n[0] = {6'd0, sel_edge};
                end
                CMD_GET_STATUS: begin
                    for (int i = 0; i < CB; i++) resp_n[i]      = cnt_pad[i*8 +: 8];
                    for (int i = 0; i < DB; i++) resp_n[CB + i] = dly_pad[i*8 +: 8];
                    resp_len_n = 4'(CB + DB);
                end
                CMD_GET_INFO: begin
                    resp_n[0]  = 8'(NUM_CH);
                    resp_n[1]  = 8'(DELAY_W);
                    resp_n[2]  = 8'(COUNT_W);
                    resp_len_n = 4'd3;
                end
                default: ;
            endcase
        end
`ifdef CMD_CHECKSUM_EN
        rsum = '0;
        for (int i = 0; i < RB; i++) begin
            if (4'(i) < resp_len_n) rsum = rsum ^ resp_n[i];
        end
        for (int i = 0; i < RB; i++) begin
            if (4'(i) == resp_len_n) resp_n[i] = rsum;
        end
        resp_len_n = resp_len_n + 4'd1;
`endif
    end

    always_comb begin
        tx_byte = resp[0];
        for (int i = 0; i < RB; i++) begin
            if (resp_idx == 4'(i)) tx_byte = resp[i];
        end
    end

    // Inter-byte timer: only runs while a request is being collected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (!receiving || rx_data_valid) begin
            timer <= '0;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cmd              <= '0;
            ch               <= '0;
            payload          <= '0;
            pay_cnt          <= '0;
            nak_flag         <= 1'b0;
            resp_len         <= '0;
            resp_idx         <= '0;
            seen_low         <= 1'b0;
            for (int i = 0; i < RB; i++) resp[i] <= '0;
            tx_data          <= '0;
            tx_en            <= 1'b0;
            delay_cycles     <= '0;
            delay_update     <= '0;
            edge_type_update <= '0;
            reset_counter    <= '0;
            for (int c = 0; c < NUM_CH; c++) edge_type[c*2 +: 2] <= 2'd1;
`ifdef CMD_CHECKSUM_EN
            csum             <= '0;
            csum_bad         <= 1'b0;
`endif
        end else begin
            tx_en            <= 1'b0;
            delay_update     <= '0;
            edge_type_update <= '0;
            reset_counter    <= '0;
            case (state)
                S_IDLE: begin
                    nak_flag <= 1'b0;
                    pay_cnt  <= '0;
`ifdef CMD_CHECKSUM_EN
                    csum_bad <= 1'b0;
                    csum     <= rx_data;
`endif
                    if (rx_data_valid && rx_data != SYNC_BYTE) begin
                        cmd <= rx_data;
                        // Unknown commands have no defined length, so they
                        // are answered immediately without waiting for more.
                        if (!rx_known) begin
                            nak_flag <= 1'b1;
                            state    <= S_EXEC;
                        end else if (rx_data == CMD_GET_INFO) begin
                            state <= S_REQ_END;
                        end else begin
                            state <= S_GET_CH;
                        end
                    end
                end
                S_GET_CH: begin
                    if (rx_data_valid) begin
                        ch <= rx_data;
`ifdef CMD_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (cmd == CMD_SET_DELAY || cmd == CMD_SET_EDGE) state <= S_GET_PAYLOAD;
                        else                                             state <= S_REQ_END;
                    end else if (timed_out) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_PAYLOAD: begin
                    if (rx_data_valid) begin
                        for (int i = 0; i < DB; i++) begin
                            if (pay_cnt == 3'(i)) payload[i*8 +: 8] <= rx_data;
                        end
                        pay_cnt <= pay_cnt + 3'd1;
`ifdef CMD_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (pay_cnt == pay_need - 3'd1) state <= S_REQ_END;
                    end else if (timed_out) begin
                        state <= S_IDLE;
                    end
                end
`ifdef CMD_CHECKSUM_EN
                S_GET_CSUM: begin
                    if (rx_data_valid) begin
                        csum_bad <= (rx_data != csum);
                        state    <= S_EXEC;
                    end else if (timed_out) begin
                        state <= S_IDLE;
                    end
                end
`endif
                S_EXEC: begin
                    for (int i = 0; i < RB; i++) resp[i] <= resp_n[i];
                    resp_len <= resp_len_n;
                    resp_idx <= '0;
                    state    <= S_TX_LOAD;
                    if (!req_bad) begin
                        case (cmd)
                            CMD_SET_DELAY: begin
                                for (int c = 0; c < NUM_CH; c++) begin
                                    if (ch_mask[c]) delay_cycles[c*DELAY_W +: DELAY_W] <= payload[DELAY_W-1:0];
                                end
                                delay_update <= ch_mask;
                            end
                            CMD_SET_EDGE: begin
                                for (int c = 0; c < NUM_CH; c++) begin
                                    if (ch_mask[c]) edge_type[c*2 +: 2] <= payload[1:0];
                                end
                                edge_type_update <= ch_mask;
                            end
                            CMD_RESET_COUNT: reset_counter <= ch_mask;
                            default: ;
                        endcase
                    end
                end
                S_TX_LOAD: begin
                    if (tx_ready) begin
                        tx_data  <= tx_byte;
                        tx_en    <= 1'b1;
                        seen_low <= 1'b0;
                        state    <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    // A byte is complete only after tx_ready has been seen
                    // low and then high again.
                    if (!tx_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        if (resp_idx + 4'd1 == resp_len) begin
                            state <= S_IDLE;
                        end else begin
                            resp_idx <= resp_idx + 4'd1;
                            state    <= S_TX_LOAD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_handler_mc.sv
// tb/tb_uart_cmd_handler_mc.sv - directed self-checking bench for uart_cmd_handler_mc
module tb_uart_cmd_handler_mc;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_data_valid;
    logic [7:0]   tx_data;
    logic         tx_en;
    logic         tx_ready;
    logic [127:0] delay_cycles;
    logic [3:0]   delay_update;
    logic [7:0]   edge_type;
    logic [3:0]   edge_type_update;
    logic [127:0] current_delay;
    logic [127:0] cd_force;
    logic [63:0]  trigger_count;
    logic [3:0]   reset_counter;
    logic         loopback;

    int checks = 0;
    int errors = 0;

    assign current_delay = loopback ? delay_cycles : cd_force;

    uart_cmd_handler_mc #(
        .NUM_CH(4), .DELAY_W(32), .COUNT_W(16), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .tx_data(tx_data), .tx_en(tx_en), .tx_ready(tx_ready),
        .delay_cycles(delay_cycles), .delay_update(delay_update),
        .edge_type(edge_type), .edge_type_update(edge_type_update),
        .current_delay(current_delay), .trigger_count(trigger_count),
        .reset_counter(reset_counter)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter model: captures each tx_en byte, then stays busy tx_hold cycles.
    int         got_total = 0;
    logic [7:0] got_mem [256];
    int         tx_hold = 2;
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_en === 1'b1) begin
                got_mem[8'(got_total)] = tx_data;
                got_total++;
                tx_ready = 1'b0;
                repeat (tx_hold) @(negedge clk);
                tx_ready = 1'b1;
            end
        end
    end

    int       du_total = 0, eu_total = 0, rc_total = 0;
    logic [3:0] du_last, eu_last, rc_last;
    always @(negedge clk) begin
        if (delay_update !== 4'd0)     begin du_total++; du_last = delay_update;     end
        if (edge_type_update !== 4'd0) begin eu_total++; eu_last = edge_type_update; end
        if (reset_counter !== 4'd0)    begin rc_total++; rc_last = reset_counter;    end
    end

    logic [95:0] exp_v, got_v;
    int          exp_n, got_n, rsp_base;
    logic [7:0]  exp_cs;
    logic [7:0]  last_req_cs;
    bit          rsp_ok;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
    endtask

    // Sends n bytes of v, most significant byte first; appends the request
    // checksum when checksums are enabled and with_cs is set.
    task automatic send_req(input logic [63:0] v, input int n, input bit with_cs);
        logic [7:0] x;
        x = 8'd0;
        for (int k = 0; k < n; k++) begin
            send_byte(v[(n-1-k)*8 +: 8]);
            x = x ^ v[(n-1-k)*8 +: 8];
        end
        last_req_cs = x;
        if (with_cs) begin
`ifdef CMD_CHECKSUM_EN
            send_byte(x);
`endif
        end
    endtask

    task automatic exp_start();
        exp_v    = '0;
        exp_n    = 0;
        exp_cs   = 8'd0;
        rsp_base = got_total;
    endtask

    task automatic exp_add(input logic [7:0] b);
        exp_v  = {exp_v[87:0], b};
        exp_n++;
        exp_cs = exp_cs ^ b;
    endtask

    task automatic exp_end();
`ifdef CMD_CHECKSUM_EN
        logic [7:0] c;
        c = exp_cs;
        exp_add(c);
`endif
    endtask

    task automatic wait_resp();
        rsp_ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (got_total - rsp_base >= exp_n) begin
                rsp_ok = 1'b1;
                break;
            end
        end
        repeat (tx_hold + 20) @(negedge clk);
        got_n = got_total - rsp_base;
        got_v = '0;
        for (int i = 0; i < got_n && i < 12; i++) got_v = {got_v[87:0], got_mem[8'(rsp_base + i)]};
    endtask

    task automatic test_reset();
        checks++;
        if (delay_cycles !== '0 || delay_update !== 4'd0 || edge_type_update !== 4'd0 || reset_counter !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: delay=%h du=%b eu=%b rc=%b, required all 0", delay_cycles, delay_update, edge_type_update, reset_counter);
        end
        checks++;
        if (edge_type !== 8'h55) begin
            errors++;
            $display("FAIL reset_edge: got %h, required 55", edge_type);
        end
        checks++;
        if (tx_en !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx: tx_en=%b tx_data=%h, required 0/00", tx_en, tx_data);
        end
    endtask

    task automatic test_set_delay();
        int du0;
        du0 = du_total;
        exp_start(); exp_add(8'hAA); exp_end();
        send_req(64'h01_02_78_56_34_12, 6, 1'b1);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL set_delay_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
        checks++;
        if (delay_cycles !== 128'h00000000_12345678_00000000_00000000) begin
            errors++;
            $display("FAIL set_delay_value: got %h, required ch2=12345678", delay_cycles);
        end
        checks++;
        if (du_total - du0 !== 1 || du_last !== 4'b0100) begin
            errors++;
            $display("FAIL set_delay_pulse: %0d cycles last %b, required 1 cycle 0100", du_total - du0, du_last);
        end
        exp_start(); exp_add(8'h78); exp_add(8'h56); exp_add(8'h34); exp_add(8'h12); exp_end();
        send_req(64'h02_02, 2, 1'b1);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL get_delay_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
    endtask

    task automatic test_broadcast_edge();
        int eu0;
        eu0 = eu_total;
        exp_start(); exp_add(8'hAA); exp_end();
        send_req(64'h03_FF_02, 3, 1'b1);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL bcast_edge_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
        checks++;
        if (edge_type !== 8'hAA) begin
            errors++;
            $display("FAIL bcast_edge_value: got %h, required aa", edge_type);
        end
        checks++;
        if (eu_total - eu0 !== 1 || eu_last !== 4'b1111) begin
            errors++;
            $display("FAIL bcast_edge_pulse: %0d cycles last %b, required 1 cycle 1111", eu_total - eu0, eu_last);
        end
        eu0 = eu_total;
        exp_start(); exp_add(8'hEE); exp_end();
        send_req(64'h03_01_07, 3, 1'b1);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL bad_edge_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
        checks++;
        if (edge_type !== 8'hAA || eu_total != eu0) begin
            errors++;
            $display("FAIL bad_edge_effect: edge %h pulses %0d, required aa and 0", edge_type, eu_total - eu0);
        end
        exp_start(); exp_add(8'h02); exp_end();
        send_req(64'h04_02, 2, 1'b1);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL get_edge_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
    endtask

    task automatic test_bad_requests();
        exp_start(); exp_add(8'hEE); exp_end();
        send_req(64'h05_04, 2, 1'b1);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL bad_ch_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
        exp_start(); exp_add(8'hEE); exp_end();
        send_req(64'h09, 1, 1'b0);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL bad_cmd_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
        exp_start(); exp_add(8'hEE); exp_end();
        send_req(64'h02_FF, 2, 1'b1);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL bcast_get_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
        exp_start(); exp_add(8'h04); exp_add(8'h20); exp_add(8'h10); exp_end();
        send_byte(8'h55);
        send_req(64'h07, 1, 1'b1);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL sync_info_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
    endtask

    task automatic test_timeout();
        int du0;
        du0 = du_total;
        exp_start(); exp_add(8'h00); exp_add(8'h00); exp_add(8'h00); exp_add(8'h00); exp_end();
        send_req(64'h01_00_11, 3, 1'b0);
        repeat (100) @(negedge clk);
        send_req(64'h02_00, 2, 1'b1);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL timeout_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
        checks++;
        if (du_total != du0 || delay_cycles[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL timeout_effect: pulses %0d ch0 %h, required 0 and 00000000", du_total - du0, delay_cycles[31:0]);
        end
    endtask

    task automatic test_status_snapshot();
        loopback            = 1'b0;
        cd_force            = delay_cycles;
        cd_force[63:32]     = 32'h0000000A;
        trigger_count       = 64'h0000_0000_0203_0000;
        tx_hold             = 50;
        exp_start();
        exp_add(8'h03); exp_add(8'h02); exp_add(8'h0A); exp_add(8'h00); exp_add(8'h00); exp_add(8'h00);
        exp_end();
        send_req(64'h05_01, 2, 1'b1);
        repeat (2) @(negedge clk);
        cd_force[63:32]      = 32'h77777777;
        trigger_count[31:16] = 16'hBEEF;
        wait_resp();
        checks++;
        if (!rsp_ok || got_v !== exp_v) begin
            errors++;
            $display("FAIL status_rsp: got %h, required %h", got_v, exp_v);
        end
        checks++;
        if (got_n !== exp_n) begin
            errors++;
            $display("FAIL status_tx_count: got %0d tx_en pulses, required %0d", got_n, exp_n);
        end
        tx_hold  = 2;
        loopback = 1'b1;
    endtask

    task automatic test_reset_count();
        int rc0;
        rc0 = rc_total;
        exp_start(); exp_add(8'hAA); exp_end();
        send_req(64'h06_03, 2, 1'b1);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_count_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
        checks++;
        if (rc_total - rc0 !== 1 || rc_last !== 4'b1000) begin
            errors++;
            $display("FAIL reset_count_pulse: %0d cycles last %b, required 1 cycle 1000", rc_total - rc0, rc_last);
        end
`ifdef CMD_CHECKSUM_EN
        rc0 = rc_total;
        exp_start(); exp_add(8'hEE); exp_end();
        send_req(64'h06_03_00, 3, 1'b0);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL bad_csum_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
        checks++;
        if (rc_total != rc0) begin
            errors++;
            $display("FAIL bad_csum_effect: %0d reset pulses, required 0", rc_total - rc0);
        end
`endif
    endtask

    task automatic test_reset_mid_response();
        tx_hold = 50;
        exp_start();
        send_req(64'h07, 1, 1'b1);
        rsp_ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (got_total - rsp_base >= 1) begin
                rsp_ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!rsp_ok) begin
            errors++;
            $display("FAIL mid_first_byte: got %0d bytes, required at least 1", got_total - rsp_base);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_en !== 1'b0 || delay_cycles !== '0 || edge_type !== 8'h55 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_outputs: tx_en=%b tx_data=%h delay=%h edge=%h, required 0/00/0/55", tx_en, tx_data, delay_cycles, edge_type);
        end
        repeat (80) @(negedge clk);
        checks++;
        if (got_total - rsp_base !== 1) begin
            errors++;
            $display("FAIL mid_tx_stopped: got %0d bytes, required 1", got_total - rsp_base);
        end
        rst_n   = 1'b1;
        tx_hold = 2;
        repeat (5) @(negedge clk);
        exp_start(); exp_add(8'h00); exp_add(8'h00); exp_add(8'h00); exp_add(8'h00); exp_end();
        send_req(64'h02_02, 2, 1'b1);
        wait_resp();
        checks++;
        if (!rsp_ok || got_n !== exp_n || got_v !== exp_v) begin
            errors++;
            $display("FAIL mid_recover_rsp: got %0d bytes %h, required %0d bytes %h", got_n, got_v, exp_n, exp_v);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        loopback      = 1'b1;
        cd_force      = '0;
        trigger_count = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_set_delay();
        test_broadcast_edge();
        test_bad_requests();
        test_timeout();
        test_status_snapshot();
        test_reset_count();
        test_reset_mid_response();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
